// File: rtl/player_mover_if.sv
// Player update bundle: keys and pose in, registered pose out, plus the grid probe handshake.
// The master side issues start, keys and pose and answers probes; the slave side is the mover.
interface player_mover_if #(
   parameter int X_W        = 14,
   parameter int Y_W        = 13,
   parameter int ANG_W      = 8,
   parameter int CELL_SHIFT = 8
);
   logic                    start;
   logic                    done;
   logic                    turn_right;
   logic                    turn_left;
   logic                    move_forward;
   logic                    move_backward;
   logic [X_W-1:0]          cur_pos_x;
   logic [Y_W-1:0]          cur_pos_y;
   logic [ANG_W-1:0]        cur_angle;
   logic [X_W:0]            dir_x;
   logic [Y_W:0]            dir_y;
   logic [X_W-1:0]          next_pos_x;
   logic [Y_W-1:0]          next_pos_y;
   logic [ANG_W-1:0]        next_angle;
   logic [X_W-CELL_SHIFT-1:0] grid_x;
   logic [Y_W-CELL_SHIFT-1:0] grid_y;
   logic                    grid_req;
   logic                    grid_ack;
   logic [2:0]              grid_out;
   logic [1:0]              blocked;

   modport master (
      output start, turn_right, turn_left, move_forward, move_backward,
             cur_pos_x, cur_pos_y, cur_angle, dir_x, dir_y, grid_ack, grid_out,
      input  done, next_pos_x, next_pos_y, next_angle, grid_x, grid_y, grid_req, blocked
   );

   modport slave (
      input  start, turn_right, turn_left, move_forward, move_backward,
             cur_pos_x, cur_pos_y, cur_angle, dir_x, dir_y, grid_ack, grid_out,
      output done, next_pos_x, next_pos_y, next_angle, grid_x, grid_y, grid_req, blocked
   );
endinterface

// File: rtl/player_mover.sv
// Rate-limited player turn/move with wall-sliding collision probes (diagonal, then X-only, then Y-only).
// Latency: 3 cycles accept-to-done without a move, +(1 + ack wait) per probe; waits on grid_ack with no timeout.
module player_mover #(
   parameter int             X_W         = 14,
   parameter int             Y_W         = 13,
   parameter int             ANG_W       = 8,
   parameter int             CELL_SHIFT  = 8,
   parameter int             TURN_SPEED  = 10,
   parameter int             SPEED_SHIFT = 0,
   parameter int             RATE_BITS   = 20,
   parameter logic [2:0]     EMPTY_CODE  = 3'd0,
   parameter logic [X_W-1:0] INIT_X      = '0,
   parameter logic [Y_W-1:0] INIT_Y      = '0,
   parameter logic [ANG_W-1:0] INIT_ANGLE = '0
) (
   input logic          clock,
   input logic          reset,
   player_mover_if.slave bus
);
   localparam int GX_W = X_W - CELL_SHIFT;
   localparam int GY_W = Y_W - CELL_SHIFT;
   localparam logic [ANG_W-1:0] TURN_A = ANG_W'(TURN_SPEED);

   typedef enum logic [2:0] {
      S_IDLE, S_PREDICT, S_PROBE_XY, S_PROBE_X, S_PROBE_Y, S_COMMIT, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [RATE_BITS-1:0] rate_cnt;
   logic                 armed;
   logic                 tick;
   logic                 accept;
   logic                 done;

   logic [ANG_W-1:0] ta;
   logic [X_W-1:0]   tx, cx, pos_x;
   logic [Y_W-1:0]   ty, cy, pos_y;
   logic [1:0]       blk;

   logic [X_W-1:0]   next_pos_x;
   logic [Y_W-1:0]   next_pos_y;
   logic [ANG_W-1:0] next_angle;
   logic [GX_W-1:0]  grid_x;
   logic [GY_W-1:0]  grid_y;
   logic             grid_req;
   logic [1:0]       blocked;

   logic turn_r, turn_l, mv_fwd, mv_bwd, has_move;
   logic in_probe, ack_hit, cell_empty;
   logic signed [X_W:0] sx;
   logic signed [Y_W:0] sy;
   logic [X_W-1:0]   tx_d;
   logic [Y_W-1:0]   ty_d;
   logic [ANG_W-1:0] ta_d;

   assign tick = &rate_cnt;

   // Opposing keys cancel; turning and moving are independent.
   assign turn_r   = bus.turn_right & ~bus.turn_left;
   assign turn_l   = bus.turn_left & ~bus.turn_right;
   assign mv_fwd   = bus.move_forward & ~bus.move_backward;
   assign mv_bwd   = bus.move_backward & ~bus.move_forward;
   assign has_move = mv_fwd | mv_bwd;

   assign sx = $signed(bus.dir_x) >>> SPEED_SHIFT;
   assign sy = $signed(bus.dir_y) >>> SPEED_SHIFT;

   assign ta_d = turn_r ? bus.cur_angle + TURN_A :
                 turn_l ? bus.cur_angle - TURN_A : bus.cur_angle;
   assign tx_d = mv_fwd ? bus.cur_pos_x + X_W'(sx) :
                 mv_bwd ? bus.cur_pos_x - X_W'(sx) : bus.cur_pos_x;
   assign ty_d = mv_fwd ? bus.cur_pos_y + Y_W'(sy) :
                 mv_bwd ? bus.cur_pos_y - Y_W'(sy) : bus.cur_pos_y;

   assign in_probe   = (state == S_PROBE_XY) || (state == S_PROBE_X) || (state == S_PROBE_Y);
   // An ack only counts while our request is actually up.
   assign ack_hit    = in_probe && grid_req && bus.grid_ack;
   assign cell_empty = (bus.grid_out == EMPTY_CODE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start && armed) begin
               accept    = 1'b1;
               state_nxt = S_PREDICT;
            end
         end
         S_PREDICT:  state_nxt = has_move ? S_PROBE_XY : S_COMMIT;
         S_PROBE_XY: if (ack_hit) state_nxt = cell_empty ? S_COMMIT : S_PROBE_X;
         S_PROBE_X:  if (ack_hit) state_nxt = cell_empty ? S_COMMIT : S_PROBE_Y;
         S_PROBE_Y:  if (ack_hit) state_nxt = S_COMMIT;
         S_COMMIT:   state_nxt = S_DONE;
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default:    state_nxt = S_IDLE;
      endcase
   end

   // A tick landing on the accept cycle wins, so that tick is not lost.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rate_cnt <= '0;
         armed    <= 1'b0;
      end else begin
         rate_cnt <= rate_cnt + RATE_BITS'(1);
         if (tick) begin
            armed <= 1'b1;
         end else if (accept) begin
            armed <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ta         <= '0;
         tx         <= '0;
         ty         <= '0;
         cx         <= '0;
         cy         <= '0;
         pos_x      <= '0;
         pos_y      <= '0;
         blk        <= 2'b00;
         next_pos_x <= INIT_X;
         next_pos_y <= INIT_Y;
         next_angle <= INIT_ANGLE;
         grid_x     <= '0;
         grid_y     <= '0;
         grid_req   <= 1'b0;
         blocked    <= 2'b00;
      end else begin
         case (state)
            S_PREDICT: begin
               ta    <= ta_d;
               tx    <= tx_d;
               ty    <= ty_d;
               cx    <= bus.cur_pos_x;
               cy    <= bus.cur_pos_y;
               pos_x <= bus.cur_pos_x;
               pos_y <= bus.cur_pos_y;
               blk   <= 2'b00;
               if (has_move) begin
                  grid_x <= tx_d[X_W-1:CELL_SHIFT];
                  grid_y <= ty_d[Y_W-1:CELL_SHIFT];
               end
            end
            S_PROBE_XY: begin
               if (ack_hit) begin
                  if (cell_empty) begin
                     pos_x <= tx;
                     pos_y <= ty;
                     blk   <= 2'b00;
                  end else begin
                     grid_x <= tx[X_W-1:CELL_SHIFT];
                     grid_y <= cy[Y_W-1:CELL_SHIFT];
                  end
               end
            end
            S_PROBE_X: begin
               if (ack_hit) begin
                  if (cell_empty) begin
                     pos_x <= tx;
                     pos_y <= cy;
                     blk   <= 2'b10;
                  end else begin
                     grid_x <= cx[X_W-1:CELL_SHIFT];
                     grid_y <= ty[Y_W-1:CELL_SHIFT];
                  end
               end
            end
            S_PROBE_Y: begin
               if (ack_hit) begin
                  pos_x <= cell_empty ? cx : cx;
                  pos_y <= cell_empty ? ty : cy;
                  blk   <= cell_empty ? 2'b01 : 2'b11;
               end
            end
            S_COMMIT: begin
               next_angle <= ta;
               next_pos_x <= pos_x;
               next_pos_y <= pos_y;
               blocked    <= blk;
            end
            default: ;
         endcase

         // Request rises one cycle after probe entry and falls on the ack cycle.
         if (ack_hit) begin
            grid_req <= 1'b0;
         end else if (in_probe && !grid_req) begin
            grid_req <= 1'b1;
         end
      end
   end

   assign bus.done       = done;
   assign bus.next_pos_x = next_pos_x;
   assign bus.next_pos_y = next_pos_y;
   assign bus.next_angle = next_angle;
   assign bus.grid_x     = grid_x;
   assign bus.grid_y     = grid_y;
   assign bus.grid_req   = grid_req;
   assign bus.blocked    = blocked;
endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover: turn/move updates against a modelled grid with delayed acks.
module tb_player_mover;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   player_mover_if bus ();

   player_mover #(.RATE_BITS(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Grid model: listed cells are walls, everything else is empty.
   int full_cells[$];
   int probe_log[$];
   int episodes  = 0;
   int ack_dly   = 2;
   int req_age   = 0;
   bit stray     = 1'b0;
   int done_cnt  = 0;

   function automatic bit is_full(input int gx, input int gy);
      foreach (full_cells[i]) if (full_cells[i] == gx * 256 + gy) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      bus.grid_ack = 1'b0;
      bus.grid_out = 3'd0;
      forever begin
         @(negedge clock);
         bus.grid_ack = 1'b0;
         if (done_cnt >= 0 && bus.done) done_cnt++;
         if (bus.grid_req) begin
            if (req_age == 0) begin
               episodes++;
               probe_log.push_back(int'(bus.grid_x) * 256 + int'(bus.grid_y));
            end
            if (req_age == ack_dly) begin
               bus.grid_ack = 1'b1;
               bus.grid_out = is_full(int'(bus.grid_x), int'(bus.grid_y)) ? 3'd1 : 3'd0;
            end
            req_age++;
         end else begin
            req_age = 0;
            if (stray) begin
               bus.grid_ack = 1'b1;
               bus.grid_out = 3'd0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic set_keys(input bit r, input bit l, input bit f, input bit b);
      bus.turn_right    = r;
      bus.turn_left     = l;
      bus.move_forward  = f;
      bus.move_backward = b;
   endtask

   task automatic set_pose(input int x, input int y, input int a, input int dx, input int dy);
      bus.cur_pos_x = 14'(x);
      bus.cur_pos_y = 13'(y);
      bus.cur_angle = 8'(a);
      bus.dir_x     = 15'(dx);
      bus.dir_y     = 14'(dy);
   endtask

   task automatic run_update(input string tag);
      bit seen;
      seen = 1'b0;
      episodes = 0;
      probe_log.delete();
      bus.start = 1'b1;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clock);
         if (bus.done) seen = 1'b1;
      end
      bus.start = 1'b0;
      check({tag, "_done"}, 32'(seen), 32'd1);
      @(negedge clock);
      check({tag, "_pulse"}, 32'(bus.done), 32'd0);
   endtask

   task automatic check_result(input string tag, input int x, input int y, input int a,
                               input int blk, input int eps);
      check({tag, "_x"},   32'(bus.next_pos_x), 32'(x));
      check({tag, "_y"},   32'(bus.next_pos_y), 32'(y));
      check({tag, "_ang"}, 32'(bus.next_angle), 32'(a));
      check({tag, "_blk"}, 32'(bus.blocked),    32'(blk));
      check({tag, "_eps"}, 32'(episodes),       32'(eps));
   endtask

   initial begin
      bus.start = 1'b0;
      set_keys(0, 0, 0, 0);
      set_pose(0, 0, 0, 0, 0);
      repeat (3) @(negedge clock);
      check("rst_done",  32'(bus.done),       32'd0);
      check("rst_req",   32'(bus.grid_req),   32'd0);
      check("rst_blk",   32'(bus.blocked),    32'd0);
      check("rst_x",     32'(bus.next_pos_x), 32'd0);
      check("rst_y",     32'(bus.next_pos_y), 32'd0);
      check("rst_ang",   32'(bus.next_angle), 32'd0);
      check("rst_gx",    32'(bus.grid_x),     32'd0);
      check("rst_gy",    32'(bus.grid_y),     32'd0);
      reset = 1'b1;

      // Turn right only: angle advances, nothing probed.
      set_pose(1000, 500, 0, 20, 30);
      set_keys(1, 0, 0, 0);
      run_update("t1");
      check_result("t1", 1000, 500, 10, 0, 0);

      // Turn left wraps below zero.
      set_pose(1234, 777, 5, 20, 30);
      set_keys(0, 1, 0, 0);
      run_update("t2");
      check_result("t2", 1234, 777, 251, 0, 0);

      // Diagonal step into an empty cell.
      set_pose(14'h1F0, 13'h0F0, 40, 20, 30);
      set_keys(0, 0, 1, 0);
      run_update("t3");
      check_result("t3", 14'h204, 13'h10E, 40, 0, 1);
      check("t3_cell0", 32'(probe_log[0]), 32'(2 * 256 + 1));

      // Diagonal blocked, slide along X.
      full_cells = '{2 * 256 + 1};
      run_update("t4");
      check_result("t4", 14'h204, 13'h0F0, 40, 2'b10, 2);
      check("t4_cell1", 32'(probe_log[1]), 32'(2 * 256 + 0));

      // Diagonal and X blocked, slide along Y.
      full_cells = '{2 * 256 + 1, 2 * 256 + 0};
      run_update("ty");
      check_result("ty", 14'h1F0, 13'h10E, 40, 2'b01, 3);

      // Everything blocked, turn still applies.
      full_cells = '{2 * 256 + 1, 2 * 256 + 0, 1 * 256 + 1};
      set_pose(14'h1F0, 13'h0F0, 100, 20, 30);
      set_keys(1, 0, 1, 0);
      run_update("t5");
      check_result("t5", 14'h1F0, 13'h0F0, 110, 2'b11, 3);
      check("t5_cell2", 32'(probe_log[2]), 32'(1 * 256 + 1));

      // Backward step subtracts the direction vector.
      full_cells.delete();
      set_keys(0, 0, 0, 1);
      run_update("bk");
      check_result("bk", 14'h1DC, 13'h0D2, 100, 0, 1);
      check("bk_cell", 32'(probe_log[0]), 32'(1 * 256 + 0));

      // Negative direction wraps x around the 14-bit space.
      set_pose(5, 13'h100, 60, -20, 0);
      set_keys(0, 0, 1, 0);
      run_update("wr");
      check_result("wr", 14'h3FF1, 13'h100, 60, 0, 1);
      check("wr_cell", 32'(probe_log[0]), 32'(63 * 256 + 1));

      // Opposing keys cancel both turn and move.
      set_pose(300, 400, 77, 20, 30);
      set_keys(1, 1, 1, 1);
      run_update("cx");
      check_result("cx", 300, 400, 77, 0, 0);

      // Reset while a probe is outstanding.
      ack_dly = 1000;
      set_pose(14'h1F0, 13'h0F0, 9, 20, 30);
      set_keys(0, 0, 1, 0);
      bus.start = 1'b1;
      begin
         bit up;
         up = 1'b0;
         for (int n = 0; n < 200 && !up; n++) begin
            @(negedge clock);
            if (bus.grid_req) up = 1'b1;
         end
         check("t6_req_up", 32'(up), 32'd1);
      end
      bus.start = 1'b0;
      done_cnt = 0;
      reset = 1'b0;
      #1;
      check("t6_req_drop", 32'(bus.grid_req),   32'd0);
      check("t6_x",        32'(bus.next_pos_x), 32'd0);
      check("t6_y",        32'(bus.next_pos_y), 32'd0);
      check("t6_ang",      32'(bus.next_angle), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      ack_dly = 2;
      stray = 1'b1;
      @(negedge clock);
      stray = 1'b0;
      repeat (40) @(negedge clock);
      check("t6_no_done", 32'(done_cnt),       32'd0);
      check("t6_no_req",  32'(bus.grid_req),   32'd0);
      check("t6_x_hold",  32'(bus.next_pos_x), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
